// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC owner, credit-limited imem requests, in-order instruction queue, redirect squash.
// Optional IFU_PERF_CNT_EN adds a saturating redirect_count output.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            je,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            flush,
    output logic            target_misalig
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rsp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [31:0]      r_q_data [DEPTH];
    logic [XLEN-1:0]  r_q_pc   [DEPTH];
    logic [31:0]      r_out_data;
    logic [XLEN-1:0]  r_out_pc;

    logic [XLEN-1:0]  w_target_al;
    logic             w_credit;
    logic             w_accept;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [CNT_W-1:0] w_out_after;
    logic [CNT_W-1:0] w_count_next;
    logic [IDX_W-1:0] w_head_next;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    assign w_target_al    = {jump_target[XLEN-1:2], 2'b00};
    assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < SUM_W'(DEPTH);
    assign imem_req_valid = (r_state == ST_FETCH) && !je && w_credit;
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_drop         = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_push         = imem_rsp_valid && (r_drop_cnt == '0) && !je;
    assign instr_valid    = (r_count != '0) && !je;
    assign w_pop          = instr_valid && instr_ready;
    assign instr_data     = r_out_data;
    assign instr_pc       = r_out_pc;
    assign flush          = je;
    assign target_misalig = je && (jump_target[1:0] != 2'b00);

    // Responses still owed by imem after this edge; a redirect turns all of them into drops.
    assign w_out_after  = r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head_next  = w_pop ? idx_inc(r_head) : r_head;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:  w_state_next = ST_FETCH;
            ST_FETCH: if (je && (w_out_after != '0)) w_state_next = ST_FLUSH;
            ST_FLUSH: if (!je && (r_drop_cnt == '0)) w_state_next = ST_FETCH;
            default:  w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_out_data    <= '0;
            r_out_pc      <= '0;
        end else begin
            r_outstanding <= w_out_after;
            if (je) begin
                r_pc       <= w_target_al;
                r_rsp_pc   <= w_target_al;
                r_drop_cnt <= w_out_after;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_accept) r_pc <= r_pc + XLEN'(4);
                if (w_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                    r_tail   <= idx_inc(r_tail);
                end
                r_count <= w_count_next;
                r_head  <= w_head_next;
                // Output register tracks the head entry and holds its value once the queue drains.
                if (w_count_next != '0) begin
                    if (w_push && (r_tail == w_head_next)) begin
                        r_out_data <= imem_rsp_data;
                        r_out_pc   <= r_rsp_pc;
                    end else begin
                        r_out_data <= r_q_data[w_head_next];
                        r_out_pc   <= r_q_pc[w_head_next];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_tail] <= imem_rsp_data;
            r_q_pc[r_tail]   <= r_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        assert (!(w_push && (r_count == CNT_W'(DEPTH))));
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_count <= '0;
        end else if (je && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small in-order imem model whose responses can be held back.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        je;
    logic [31:0] jump_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        flush;
    logic        target_misalig;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] redirect_count;
`endif

    logic        hold;
    int          n_checks;
    int          n_err;
    logic [31:0] pend [$];

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .je             (je),
        .jump_target    (jump_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .flush          (flush),
        .target_misalig (target_misalig)
`ifdef IFU_PERF_CNT_EN
        ,
        .redirect_count (redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // imem: one-cycle in-order responses unless hold is set
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
            if (!hold && pend.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= dat(pend.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        rst_n = 1'b0;
        je = 1'b0;
        jump_target = 32'h0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        hold = 1'b0;
        #13;
        chk1 ("rst_req_valid", imem_req_valid, 1'b0);
        chk32("rst_req_addr", imem_req_addr, 32'h0);
        chk1 ("rst_instr_valid", instr_valid, 1'b0);
        chk32("rst_instr_data", instr_data, 32'h0);
        chk32("rst_instr_pc", instr_pc, 32'h0);
        chk1 ("rst_flush", flush, 1'b0);
        chk1 ("rst_misalig", target_misalig, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic streaming fetch
        tick();
        chk1 ("t1_req_valid_e1", imem_req_valid, 1'b1);
        chk32("t1_addr_e1", imem_req_addr, 32'h0);
        tick();
        chk32("t1_addr_e2", imem_req_addr, 32'h4);
        chk1 ("t1_ivalid_e2", instr_valid, 1'b0);
        tick();
        chk1 ("t1_ivalid_e3", instr_valid, 1'b1);
        chk32("t1_ipc_e3", instr_pc, 32'h0);
        chk32("t1_idata_e3", instr_data, 32'h5A5A_0000);
        chk1 ("t1_credit_stall_e3", imem_req_valid, 1'b0);
        tick();
        chk32("t1_ipc_e4", instr_pc, 32'h4);
        chk32("t1_addr_e4", imem_req_addr, 32'h8);
        chk1 ("t1_req_valid_e4", imem_req_valid, 1'b1);
        tick();
        chk1 ("t1_ivalid_e5", instr_valid, 1'b0);
        chk32("t1_ipc_hold_e5", instr_pc, 32'h4);

        // decode stalled: credits exhaust
        instr_ready = 1'b0;
        tick();
        chk1 ("t2_req_valid_e6", imem_req_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1 ("t2_req_stall", imem_req_valid, 1'b0);
        end
        chk32("t2_head_pc", instr_pc, 32'h8);
        chk32("t2_addr", imem_req_addr, 32'h10);
        instr_ready = 1'b1;
        tick();
        chk32("t2_ipc_after_pop", instr_pc, 32'hC);
        chk1 ("t2_req_resume", imem_req_valid, 1'b1);

        // redirect with two requests in flight
        hold = 1'b1;
        tick();
        chk32("t3_addr_e11", imem_req_addr, 32'h14);
        tick();
        chk1 ("t3_req_full_e12", imem_req_valid, 1'b0);
        je = 1'b1;
        jump_target = 32'h100;
        hold = 1'b0;
        #1;
        chk1 ("t3_flush", flush, 1'b1);
        chk1 ("t3_ivalid_je", instr_valid, 1'b0);
        chk1 ("t3_misalig0", target_misalig, 1'b0);
        tick();
        je = 1'b0;
        #1;
        chk32("t3_addr_redirect", imem_req_addr, 32'h100);
        chk1 ("t3_req_flush_state", imem_req_valid, 1'b0);
        tick();
        tick();
        chk1 ("t3_req_still_flush", imem_req_valid, 1'b0);
        chk1 ("t3_stale_dropped", instr_valid, 1'b0);
        tick();
        chk1 ("t3_req_fetch", imem_req_valid, 1'b1);
        chk32("t3_addr_fetch", imem_req_addr, 32'h100);
        tick();
        chk1 ("t3_ivalid_e17", instr_valid, 1'b0);
        tick();
        chk1 ("t3_ivalid_e18", instr_valid, 1'b1);
        chk32("t3_ipc_target", instr_pc, 32'h100);
        chk32("t3_idata_target", instr_data, 32'h5A5A_0100);

        // misaligned redirect
        je = 1'b1;
        jump_target = 32'h102;
        #1;
        chk1 ("t4_misalig", target_misalig, 1'b1);
        chk1 ("t4_no_req", imem_req_valid, 1'b0);
        tick();
        je = 1'b0;
        #1;
        chk1 ("t4_misalig_clear", target_misalig, 1'b0);
        chk32("t4_addr_aligned", imem_req_addr, 32'h100);
        chk1 ("t4_req_valid", imem_req_valid, 1'b1);
        chk1 ("t4_queue_cleared", instr_valid, 1'b0);

        // imem backpressure at 0x8
        je = 1'b1;
        jump_target = 32'h8;
        tick();
        je = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk32("t5_addr_start", imem_req_addr, 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk32("t5_addr_stable", imem_req_addr, 32'h8);
            chk1 ("t5_req_held", imem_req_valid, 1'b1);
        end
        imem_req_ready = 1'b1;
        tick();
        chk32("t5_addr_resume", imem_req_addr, 32'hC);
`ifdef IFU_PERF_CNT_EN
        chk32("t6_redirect_count", redirect_count, 32'd3);
`endif

        // reset with a full queue
        instr_ready = 1'b0;
        tick();
        tick();
        tick();
        chk1 ("t6_full_ivalid", instr_valid, 1'b1);
        chk32("t6_full_ipc", instr_pc, 32'h8);
        chk1 ("t6_full_no_req", imem_req_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1 ("t6_rst_req_valid", imem_req_valid, 1'b0);
        chk32("t6_rst_addr", imem_req_addr, 32'h0);
        chk1 ("t6_rst_ivalid", instr_valid, 1'b0);
        chk32("t6_rst_idata", instr_data, 32'h0);
        chk32("t6_rst_ipc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk32("t6_rst_redirect_count", redirect_count, 32'd0);
`endif
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk1 ("t6_post_req_valid", imem_req_valid, 1'b1);
        chk32("t6_post_addr", imem_req_addr, 32'h0);
        tick();
        chk32("t6_post_addr_next", imem_req_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
